output_display_driver: RTL
==========================

// Module: output_display_driver
// PURPOSE
//  Consumes the 8-bit value held by the SAP-1 output register and drives a 3-digit multiplexed
//  7-segment display (common-anode, active-low) with its unsigned decimal value 000..255.
//  Converts binary to BCD with a sequential shift-add-3 engine.
//  Time-multiplexes the three digits at a rate set by a prescaler.
// PARAMETERS
//  SCAN_DIV  1024  clocks each digit is held before the scan advances; legal range >= 2
// PORTS
//  CLK            in   1  system clock; all state updates on rising edge
//  CLR            in   1  asynchronous, active-high reset
//  display_input  in   8  value from the output register (sampled continuously)
//  seg_bar        out  7  segments {g,f,e,d,c,b,a}, active-low
//  digit_bar      out  3  digit enables {hundreds,tens,ones}, active-low, one-hot
//  busy           out  1  high while a conversion is in progress
// BEHAVIOUR
//  Reset (CLR=1, async): seg_bar=7'h7F; digit_bar=3'b111; busy=0; last_value=0; BCD/display
//   regs=0; prescaler=0; digit index=0; FSM=IDLE.
//  Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: if display_input != last_value, capture display_input into shift reg and last_value,
//    clear BCD accum and bit count, set busy=1, go to SHIFT.
//   SHIFT: each clock add 3 to any BCD nibble >= 5, then shift {bcd,shift} left by 1.
//    After exactly 8 shifts, go to DONE.
//   DONE: copy hundreds(2b)/tens(4b)/ones(4b) into display regs; busy=0; go to IDLE.
//  Latency: input change present at edge N (capture) -> display regs updated at edge N+9.
//   busy is high from edge N through edge N+9.
//  Input changes during SHIFT/DONE are ignored. They are re-detected in IDLE because comparison
//   is against last_value, so the display always converges to the final stable input.
//  Scan: prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index
//   advances 0(ones) -> 1(tens) -> 2(hundreds) -> 0.
//   digit_bar and seg_bar are registered from the same index in the same edge, so no ghosting.
//  After reset release, the first edge drives digit_bar=3'b110 with the ones digit (shows 000).
//  Decode (seg_bar): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010,
//   6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibble values > 9 are unreachable;
//   decode them as blank (7'h7F).
//  Reset mid-conversion aborts immediately; last_value=0, so a nonzero input restarts
//   conversion at the first edge after release.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - hundreds digit blanked (seg_bar=7'h7F) when it is 0;
//   - tens digit blanked when hundreds=0 and tens=0;
//   - ones digit is never blanked;
//   - digit_bar scanning is unchanged.
//  LEADING_ZERO_BLANK_EN undefined: all three digits always shown (e.g. 007).
// STRUCTURE
//  Shared header SAP_1_defs.vh (include-guarded), holding:
//   - seven-segment pattern constants for 0-9 and blank;
//   - digit count (3);
//   - FSM state encodings IDLE/SHIFT/DONE.
//  Sub-module bin_to_bcd_8:
//   - ports: CLK, CLR, start, bin[7:0], bcd[9:0], busy, done;
//   - contains the FSM and the shift-add-3 datapath.
//  Top level holds last_value, change detect, display regs, prescaler, scan index and
//   segment decode.
// TESTING (SCAN_DIV=4 unless noted)
//  1. Reset, display_input=8'h00 -> busy stays 0; digits cycle ones/tens/hundreds every 4 clks,
//     all seg_bar=1000000.
//  2. display_input=8'h32 -> busy high 10 edges; then ones=1000000, tens=0010010,
//     hundreds=1000000 (050).
//  3. display_input=8'hD8 -> hundreds=0100100, tens=1111001, ones=0000010 (216);
//     8'hFF -> 255.
//  4. Change 8'h32 -> 8'hD8 at 3rd SHIFT cycle -> 050 committed first, then a second
//     conversion; final display 216.
//  5. Assert CLR mid-SHIFT -> all outputs at reset values asynchronously;
//     after release with 8'hD8 -> 216 at edge 10.
//  6. LEADING_ZERO_BLANK_EN defined, 8'h07 -> hundreds and tens seg_bar=7'h7F, ones=1111000;
//     8'h00 -> ones shows 0.

Source files
------------

// File: rtl/output_display_driver_pkg.sv
// Shared constants for the SAP-1 output display: segment patterns, digit count, FSM states.
// Segment vectors are {g,f,e,d,c,b,a}, active-low, for a common-anode display.
package output_display_driver_pkg;

  localparam int DIGIT_COUNT = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Codes above 9 cannot come out of the converter; show them dark rather than garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/output_display_driver_bin_to_bcd_8.sv
// Sequential shift-add-3 converter: 8-bit binary to 10-bit BCD {hundreds[1:0],tens,ones}.
// One capture clock, eight shift clocks, one done clock; busy covers capture through done.
module bin_to_bcd_8
  import output_display_driver_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       start,
  input  logic [7:0] bin,
  output logic [9:0] bcd,
  output logic       busy,
  output logic       done
);

  conv_state_t r_state;
  logic [7:0]  r_shift;
  logic [9:0]  r_bcd;
  logic [2:0]  r_count;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_ones_adj;
  logic [3:0]  w_tens_adj;

  // Hundreds never exceeds 2 for an 8-bit input, so only tens and ones need correcting.
  assign w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
  assign w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shift <= bin;
            r_bcd   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd   <= {r_bcd[8], w_tens_adj, w_ones_adj, r_shift[7]};
          r_shift <= {r_shift[6:0], 1'b0};
          r_count <= r_count + 3'd1;
          if (r_count == 3'd7) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd  = r_bcd;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: rtl/output_display_driver.sv
// SAP-1 output display: converts the output register to decimal and scans 3 common-anode digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module output_display_driver
  import output_display_driver_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] display_input,
  output logic [6:0] seg_bar,
  output logic [2:0] digit_bar,
  output logic       busy
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [7:0]    r_last_value;
  logic [1:0]    r_hund;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg_bar;
  logic [2:0]    r_digit_bar;

  logic          w_start;
  logic          w_busy;
  logic          w_done;
  logic [9:0]    w_bcd;
  logic [3:0]    w_nib       [DIGIT_COUNT];
  logic [6:0]    w_digit_seg [DIGIT_COUNT];
  logic [DIGIT_COUNT-1:0] w_blank;
  logic [6:0]    w_seg_sel;
  logic [2:0]    w_digit_sel;

  // Compare against the last captured value so changes made mid-conversion are caught later.
  assign w_start = !w_busy && (display_input != r_last_value);

  bin_to_bcd_8 u_bcd (
    .CLK   (CLK),
    .CLR   (CLR),
    .start (w_start),
    .bin   (display_input),
    .bcd   (w_bcd),
    .busy  (w_busy),
    .done  (w_done)
  );

  assign w_nib[0] = r_ones;
  assign w_nib[1] = r_tens;
  assign w_nib[2] = {2'b00, r_hund};

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = {(r_hund == 2'd0), (r_hund == 2'd0) && (r_tens == 4'd0), 1'b0};
`else
  assign w_blank = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT_COUNT; gi++) begin : g_dec
      assign w_digit_seg[gi] = w_blank[gi] ? SEG_BLANK : seg_decode(w_nib[gi]);
    end
  endgenerate

  always_comb begin
    w_seg_sel   = SEG_BLANK;
    w_digit_sel = 3'b111;
    case (r_idx)
      2'd0: begin
        w_seg_sel   = w_digit_seg[0];
        w_digit_sel = 3'b110;
      end
      2'd1: begin
        w_seg_sel   = w_digit_seg[1];
        w_digit_sel = 3'b101;
      end
      2'd2: begin
        w_seg_sel   = w_digit_seg[2];
        w_digit_sel = 3'b011;
      end
      default: begin
        w_seg_sel   = SEG_BLANK;
        w_digit_sel = 3'b111;
      end
    endcase
  end

  // Segments and digit enable come from the same index on the same edge, so no ghosting.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_last_value <= '0;
      r_hund       <= '0;
      r_tens       <= '0;
      r_ones       <= '0;
      r_presc      <= '0;
      r_idx        <= '0;
      r_seg_bar    <= SEG_BLANK;
      r_digit_bar  <= 3'b111;
    end else begin
      if (w_start) begin
        r_last_value <= display_input;
      end
      if (w_done) begin
        r_hund <= w_bcd[9:8];
        r_tens <= w_bcd[7:4];
        r_ones <= w_bcd[3:0];
      end
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_seg_bar   <= w_seg_sel;
      r_digit_bar <= w_digit_sel;
    end
  end

  assign seg_bar   = r_seg_bar;
  assign digit_bar = r_digit_bar;
  assign busy      = w_busy;

endmodule
